// File: rtl/nios_onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// nios_onchip_ram_pipelined
//
// Single-port on-chip RAM with an Avalon-MM slave interface. It serves as
// program/data memory for the NIOS instruction and data masters. Reads are
// fully pipelined and return in order through readdatavalid. An output
// register can be added, out-of-range accesses are handled safely, and a
// zero-clear sweep after reset can be compiled in.
//
// Compile-time option:
//   ONCHIP_RAM_CLEAR_EN - when defined, a CLEAR/READY sweep FSM writes zero
//                         to every word after each reset. waitrequest stays
//                         high until the sweep has finished. INIT_FILE then
//                         has no effect on the contents.
//
// Parameters:
//   DATA_WIDTH  data width in bits (must be a multiple of 8)
//   ADDR_WIDTH  word-address width
//   DEPTH       number of words (DEPTH <= 2**ADDR_WIDTH)
//   OUT_REG     0: read latency 1, 1: extra output register, latency 2
//   INIT_FILE   memory image handed to the vendor RAM inference
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous-assert, active-low reset
//   address        word address
//   byteenable     write lane enables, one per byte
//   chipselect     slave select
//   read / write   transfer requests (a write wins when both are high)
//   writedata      write data
//   clken          global clock enable
//   reset_req      reset-request stall (treated as a clock-enable drop)
//   readdata       read data, meaningful only while readdatavalid is high
//   readdatavalid  one pulse per accepted read
//   waitrequest    no request is accepted while this is high
// ---------------------------------------------------------------------------
module nios_onchip_ram_pipelined #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 8192,
    parameter int OUT_REG    = 0,
    parameter     INIT_FILE  = "nios_onchip_ram.hex"
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH-1:0]   writedata,
    input  logic                    clken,
    input  logic                    reset_req,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid,
    output logic                    waitrequest
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                  clocken0;
    logic                  clearing;
    logic                  clear_we;
    logic [IDX_W-1:0]      clear_idx;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  in_range;
    logic [IDX_W-1:0]      rd_idx;
    logic [IDX_W-1:0]      mem_idx;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [NUM_LANES-1:0]  we_lane;

    // The vendor flow picks up the init image from this attribute.
    (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] ram_q;
    logic                  v1_reg;
    logic                  hit1_reg;
    logic [DATA_WIDTH-1:0] data1;

    // The init image only affects the contents through the attribute above.
    logic unused_params;
    assign unused_params = ^INIT_FILE;

    assign clocken0    = clken & ~reset_req;
    assign waitrequest = clearing | ~clocken0;

    // Requests can only be accepted while enabled and not sweeping, so every
    // state change below that is caused by a request is implicitly enabled.
    assign wr_acc   = chipselect & write & ~waitrequest;
    assign rd_acc   = chipselect & read & ~write & ~waitrequest;
    assign in_range = (32'(address) < DEPTH);
    assign rd_idx   = address[IDX_W-1:0];

`ifdef ONCHIP_RAM_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] cnt_reg;

    // One zero word is written per enabled cycle. The last write (at
    // DEPTH-1) moves to READY, which is left only through reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_CLEAR;
            cnt_reg   <= '0;
        end else if (clocken0 && (state_reg == ST_CLEAR)) begin
            if (cnt_reg == IDX_W'(DEPTH - 1)) begin
                state_reg <= ST_READY;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign clearing  = (state_reg == ST_CLEAR);
    assign clear_we  = clearing & clocken0;
    assign clear_idx = cnt_reg;
`else
    assign clearing  = 1'b0;
    assign clear_we  = 1'b0;
    assign clear_idx = '0;
`endif

    // The sweep and host writes share the single port; the sweep always
    // takes priority because host requests are held off while it runs.
    assign mem_idx   = clearing ? clear_idx : rd_idx;
    assign mem_wdata = clearing ? '0 : writedata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane_we
            assign we_lane[gi] = clear_we | (wr_acc & in_range & byteenable[gi]);
        end
    endgenerate

    // Byte-lane write loop in one process so it maps onto a byte-enabled
    // block RAM port.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (we_lane[i]) begin
                mem[mem_idx][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            end
        end
    end

    // Registered read port without reset so it stays inside the RAM
    // primitive. It freezes with the enable so held data survives a stall.
    always_ff @(posedge clk) begin
        if (clocken0) begin
            ram_q <= mem[rd_idx];
        end
    end

    // hit1_reg is set only for an accepted, in-range read. Out-of-range
    // reads, idle cycles and the reset state therefore all present zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1_reg   <= 1'b0;
            hit1_reg <= 1'b0;
        end else if (clocken0) begin
            v1_reg   <= rd_acc;
            hit1_reg <= rd_acc & in_range;
        end
    end

    assign data1 = hit1_reg ? ram_q : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] rdata_reg;
            logic                  v2_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rdata_reg <= '0;
                    v2_reg    <= 1'b0;
                end else if (clocken0) begin
                    rdata_reg <= data1;
                    v2_reg    <= v1_reg;
                end
            end

            assign readdata      = rdata_reg;
            assign readdatavalid = v2_reg;
        end else begin : g_no_out_reg
            assign readdata      = data1;
            assign readdatavalid = v1_reg;
        end
    endgenerate

endmodule

// File: tb/tb_nios_onchip_ram_pipelined.sv
// ---------------------------------------------------------------------------
// Testbench for nios_onchip_ram_pipelined. Two instances share all inputs:
// dut0 (OUT_REG=0, latency 1) and dut1 (OUT_REG=1, latency 2). A directed
// vector table covers the main read/write behaviour. Hand-written sequences
// cover stalls, reset during operation and, with ONCHIP_RAM_CLEAR_EN, the
// clear sweep.
// ---------------------------------------------------------------------------
module tb_nios_onchip_ram_pipelined;

    localparam int AW = 13;
`ifdef ONCHIP_RAM_CLEAR_EN
    localparam int DEPTH_T = 16;
`else
    localparam int DEPTH_T = 6000;
`endif
    localparam logic [AW-1:0] OOR = AW'(DEPTH_T);

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b0;
    logic          cs        = 1'b0;
    logic          rd        = 1'b0;
    logic          wr        = 1'b0;
    logic          clken     = 1'b1;
    logic          reset_req = 1'b0;
    logic [AW-1:0] address   = '0;
    logic [3:0]    be        = '0;
    logic [31:0]   wd        = '0;

    logic [31:0] rdata0, rdata1;
    logic        rv0, rv1, wreq0, wreq1;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    nios_onchip_ram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH_T), .OUT_REG(0),
        .INIT_FILE("nios_onchip_ram.hex")
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(be),
        .chipselect(cs), .read(rd), .write(wr), .writedata(wd),
        .clken(clken), .reset_req(reset_req), .readdata(rdata0),
        .readdatavalid(rv0), .waitrequest(wreq0)
    );

    nios_onchip_ram_pipelined #(
        .DATA_WIDTH(32), .ADDR_WIDTH(AW), .DEPTH(DEPTH_T), .OUT_REG(1),
        .INIT_FILE("nios_onchip_ram.hex")
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .byteenable(be),
        .chipselect(cs), .read(rd), .write(wr), .writedata(wd),
        .clken(clken), .reset_req(reset_req), .readdata(rdata1),
        .readdatavalid(rv1), .waitrequest(wreq1)
    );

    typedef struct {
        logic          c, r, w;
        logic [AW-1:0] a;
        logic [3:0]    b;
        logic [31:0]   d;
        logic          ev0;
        logic [31:0]   ed0;
        logic          chk0;
        logic          ev1;
        logic [31:0]   ed1;
        logic          chk1;
    } vec_t;

    localparam int NV = 16;
    vec_t vt [NV];

    function automatic vec_t mk(input logic c, input logic r, input logic w,
                                input logic [AW-1:0] a, input logic [3:0] b,
                                input logic [31:0] d,
                                input logic ev0, input logic [31:0] ed0, input logic chk0,
                                input logic ev1, input logic [31:0] ed1, input logic chk1);
        vec_t v;
        v.c = c; v.r = r; v.w = w; v.a = a; v.b = b; v.d = d;
        v.ev0 = ev0; v.ed0 = ed0; v.chk0 = chk0;
        v.ev1 = ev1; v.ed1 = ed1; v.chk1 = chk1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [3:0] b, input logic [31:0] d);
        cs = c; rd = r; wr = w; address = a; be = b; wd = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, 4'h0, 32'h0);
    endtask

    // Waits while waitrequest is high and returns how many cycles that took.
    task automatic wait_sweep(output int n);
        n = 0;
        while (wreq0 && n < 200) begin
            step();
            n++;
        end
    endtask

    // A read of address 5 is accepted, then the enable is dropped for three
    // cycles, either through clken or through reset_req.
    task automatic stall_test(input logic use_req);
        int    cnt0, cnt1;
        logic  stalled;
        string tag;
        tag = use_req ? "req" : "clken";
        drive(1'b1, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0);
        step();
        idle();
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 6; k++) begin
            stalled = (k < 3);
            if (use_req) reset_req = stalled; else clken = !stalled;
            #1;
            if (stalled) begin
                check($sformatf("stall_%s_wreq_%0d", tag, k), {31'b0, wreq0}, 32'd1);
                check($sformatf("stall_%s_held_v0_%0d", tag, k), {31'b0, rv0}, 32'd1);
                check($sformatf("stall_%s_held_d0_%0d", tag, k), rdata0, 32'hDEADBEEF);
            end else begin
                cnt0 += int'(rv0);
                cnt1 += int'(rv1);
                if (rv1) check($sformatf("stall_%s_d1", tag), rdata1, 32'hDEADBEEF);
            end
            step();
        end
        check($sformatf("stall_%s_pulses0", tag), cnt0, 32'd1);
        check($sformatf("stall_%s_pulses1", tag), cnt1, 32'd1);
        clken = 1'b1;
        reset_req = 1'b0;
    endtask

    initial begin
        int n;

        // Table: expected outputs are the values seen right after each row's edge.
        vt[0]  = mk(1,0,1, 13'd5, 4'hF, 32'hDEADBEEF, 0,32'h0,0,          0,32'h0,0);
        vt[1]  = mk(1,1,0, 13'd5, 4'hF, 32'h0,        1,32'hDEADBEEF,1,   0,32'h0,0);
        vt[2]  = mk(1,1,0, 13'd6, 4'hF, 32'h0,        1,32'h0,0,          1,32'hDEADBEEF,1);
        vt[3]  = mk(1,1,0, 13'd5, 4'hF, 32'h0,        1,32'hDEADBEEF,1,   1,32'h0,0);
        vt[4]  = mk(0,0,0, 13'd0, 4'h0, 32'h0,        0,32'h0,0,          1,32'hDEADBEEF,1);
        vt[5]  = mk(0,0,0, 13'd0, 4'h0, 32'h0,        0,32'h0,0,          0,32'h0,0);
        vt[6]  = mk(1,0,1, 13'd0, 4'hF, 32'h11223344, 0,32'h0,0,          0,32'h0,0);
        vt[7]  = mk(1,0,1, 13'd0, 4'h5, 32'hAABBCCDD, 0,32'h0,0,          0,32'h0,0);
        vt[8]  = mk(1,1,0, 13'd0, 4'hF, 32'h0,        1,32'h11BB33DD,1,   0,32'h0,0);
        vt[9]  = mk(1,0,1, OOR,   4'hF, 32'hFFFFFFFF, 0,32'h0,0,          1,32'h11BB33DD,1);
        vt[10] = mk(1,1,0, OOR,   4'hF, 32'h0,        1,32'h0,1,          0,32'h0,0);
        vt[11] = mk(1,1,0, 13'd0, 4'hF, 32'h0,        1,32'h11BB33DD,1,   1,32'h0,1);
        vt[12] = mk(1,1,1, 13'd3, 4'hF, 32'h12345678, 0,32'h0,0,          1,32'h11BB33DD,1);
        vt[13] = mk(1,1,0, 13'd3, 4'hF, 32'h0,        1,32'h12345678,1,   0,32'h0,0);
        vt[14] = mk(0,0,0, 13'd0, 4'h0, 32'h0,        0,32'h0,0,          1,32'h12345678,1);
        vt[15] = mk(0,0,0, 13'd0, 4'h0, 32'h0,        0,32'h0,0,          0,32'h0,0);

        // Reset state
        step();
        step();
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rv0", {31'b0, rv0}, 32'd0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_rv1", {31'b0, rv1}, 32'd0);
`ifdef ONCHIP_RAM_CLEAR_EN
        check("rst_wreq", {31'b0, wreq0}, 32'd1);
        reset_n = 1'b1;
        wait_sweep(n);
        check("sweep_initial_len", n, 32'd16);
`else
        check("rst_wreq", {31'b0, wreq0}, 32'd0);
        reset_n = 1'b1;
        step();
`endif

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].c, vt[i].r, vt[i].w, vt[i].a, vt[i].b, vt[i].d);
            #1;
            check($sformatf("vec%0d_wreq", i), {31'b0, wreq0}, 32'd0);
            step();
            check($sformatf("vec%0d_rv0", i), {31'b0, rv0}, {31'b0, vt[i].ev0});
            if (vt[i].ev0 && vt[i].chk0) check($sformatf("vec%0d_rd0", i), rdata0, vt[i].ed0);
            check($sformatf("vec%0d_rv1", i), {31'b0, rv1}, {31'b0, vt[i].ev1});
            if (vt[i].ev1 && vt[i].chk1) check($sformatf("vec%0d_rd1", i), rdata1, vt[i].ed1);
        end
        idle();

        // Stalls through clken and through reset_req
        stall_test(1'b0);
        stall_test(1'b1);

        // A reset while a read is in flight drops the read.
        drive(1'b1, 1'b1, 1'b0, 13'd5, 4'hF, 32'h0);
        step();
        reset_n = 1'b0;
        #1;
        check("rst_drop_rv0", {31'b0, rv0}, 32'd0);
        check("rst_drop_rd0", rdata0, 32'h0);
        idle();
        step();
        check("rst_drop_rv1_a", {31'b0, rv1}, 32'd0);
        reset_n = 1'b1;
`ifdef ONCHIP_RAM_CLEAR_EN
        wait_sweep(n);
        check("sweep_after_drop_len", n, 32'd16);
`else
        step();
        step();
`endif
        check("rst_drop_rv1_b", {31'b0, rv1}, 32'd0);

`ifdef ONCHIP_RAM_CLEAR_EN
        // Full sweep clears the words that the table wrote.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wait_sweep(n);
        check("sweep_len", n, 32'd16);
        for (int a = 0; a < 16; a++) begin
            drive(1'b1, 1'b1, 1'b0, AW'(a), 4'hF, 32'h0);
            step();
            check($sformatf("clear_rv0_%0d", a), {31'b0, rv0}, 32'd1);
            check($sformatf("clear_rd0_%0d", a), rdata0, 32'h0);
        end
        idle();
        step();
        check("clear_rd1_last", rdata1, 32'h0);

        // A reset at sweep count 7 restarts the sweep from zero.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) step();
        check("sweep_mid_busy", {31'b0, wreq0}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        wait_sweep(n);
        check("sweep_restart_len", n, 32'd16);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/nios_onchip_ram_pipelined.md
# nios_onchip_ram_pipelined

Parametrised single-port on-chip RAM Avalon-MM slave for the NIOS Qsys system. It generalises the fixed 32-bit x 8192 on-chip memory in width and depth and adds a pipelined read interface (`readdatavalid`), an optional output register, and out-of-range address handling. An optional post-reset zero-clear sweep is also provided. It sits on the instruction/data master as program and data memory.

## Interface
- `DATA_WIDTH`, 32: data width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 13: word-address width.
- `DEPTH`, 8192: number of words; DEPTH <= 2^ADDR_WIDTH.
- `OUT_REG`, 0: 0 gives read latency 1; 1 adds an output register, giving latency 2.
- `INIT_FILE`, "nios_onchip_ram.hex": memory init image; ignored for contents when the clear sweep is compiled in.

- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous assert, active-low.
- `address`  in  ADDR_WIDTH  word address.
- `byteenable`  in  DATA_WIDTH/8  write lane enables.
- `chipselect`  in  1  slave select.
- `read`  in  1  read request.
- `write`  in  1  write request.
- `writedata`  in  DATA_WIDTH  write data.
- `clken`  in  1  global clock enable.
- `reset_req`  in  1  reset-request stall; the internal enable is `clocken0 = clken & ~reset_req`.
- `readdata`  out  DATA_WIDTH  read data, valid only with `readdatavalid`.
- `readdatavalid`  out  1  one-cycle pulse per accepted read.
- `waitrequest`  out  1  slave busy; no request is accepted while high.

## Operation
- **Accept conditions:**
  - A write is accepted when `chipselect & write & ~waitrequest`.
  - A read is accepted when `chipselect & read & ~write & ~waitrequest`.
  - If `read` and `write` are both high, only the write is performed and no `readdatavalid` is produced.
- **Writes:**
  - Each byte lane i is updated only if `byteenable[i]`.
  - Writes to `address >= DEPTH` are discarded.
- **Reads:**
  - Reads are fully pipelined, one per cycle, with in-order return.
  - A read to `address >= DEPTH` returns all zeros with a normal `readdatavalid`.
- **Read-during-write:** a same-address read in the cycle after a write returns the new data. There is no same-cycle hazard on a single port.
- **`waitrequest`:** equals `clearing | ~clocken0`, computed combinationally.
- **Stall (`clocken0 = 0`):**
  - The read pipeline, output register and sweep counter all freeze.
  - `readdata` and `readdatavalid` hold their values; a valid pulse held across a stall is presented exactly once, when enable returns.
- **Sweep FSM** (only with the macro):
  - States: `CLEAR` and `READY`.
  - Reset enters `CLEAR` with counter = 0.
  - In `CLEAR`, each enabled cycle writes all-zero to `mem[counter]` and increments the counter.
  - At counter = DEPTH-1 the FSM writes that word and goes to `READY`.
  - `READY` is terminal until the next reset.
- **Reset mid-operation:**
  - In-flight reads are dropped, with no `readdatavalid`.
  - The sweep restarts from 0.
  - RAM contents are not otherwise altered by reset.

## Timing
- **Reset values:**
  - `readdata = 0`.
  - `readdatavalid = 0`.
  - `waitrequest = 1` with the macro; `waitrequest = ~clocken0` without it.
- **Read latency** (enabled cycles from the accept edge to `readdatavalid` high):
  - `OUT_REG=0`: data valid 1 cycle after the accept edge.
  - `OUT_REG=1`: 2 cycles after.
- **Write:** takes effect at the accept edge and is visible to a read accepted on the next cycle.
- **Throughput:** one transfer per enabled cycle.
- **Sweep duration:** DEPTH enabled cycles after `reset_n` rises. `waitrequest` falls in the cycle after the last clear write.

## Configuration
- **`ONCHIP_RAM_CLEAR_EN` defined:**
  - The sweep FSM and a $clog2(DEPTH)-bit counter are compiled in.
  - Memory reads zero after every reset.
  - `waitrequest` is high for DEPTH enabled cycles after reset.
- **Not defined:**
  - No FSM.
  - Contents come from `INIT_FILE` at configuration and survive `reset_n`.
  - `waitrequest = ~clocken0`.

## Test plan
- **Back-to-back pipelined reads** (`OUT_REG=1`, macro off, default params): write 0xDEADBEEF to address 5, then read 5, 6, 5 on consecutive cycles. Required: `readdatavalid` high exactly on cycles +2, +3, +4 after the first read, returning 0xDEADBEEF, the INIT_FILE word at 6, then 0xDEADBEEF.
- **Byte lanes:** write 0x11223344 to address 0, then write 0xAABBCCDD with `byteenable = 4'b0101`. Required: a read of address 0 returns 0x11BB33DD.
- **Out of range:** with DEPTH=6000, write 0xFFFFFFFF to address 6000, then read address 6000. Required: the read returns 0x00000000 with `readdatavalid` pulsed, and address 0 is unchanged.
- **Clear sweep** (macro on, DEPTH=16): pulse `reset_n` low, then release. Required: `waitrequest` high for exactly 16 cycles; reads of addresses 0..15 afterwards all return 0. Also pulse `reset_n` low at sweep count 7; required: the count restarts and `waitrequest` is high for 16 more cycles.
- **Stall:** issue a read, then drop `clken` for 3 cycles in the cycle after accept. Required: `waitrequest` high during the stall, `readdatavalid` held, and exactly one valid pulse delivered when `clken` returns. Raising `reset_req` instead of dropping `clken` must give identical behaviour.
- **Read and write together:** assert `read` and `write` on address 3 with writedata 0x12345678. Required: no `readdatavalid`, and a subsequent read of address 3 returns 0x12345678.
